// File: rtl/uart_cmd_bridge.sv
// UART command bridge: decodes 'W'/'R' byte packets from the RX FIFO into
// register-bus transactions and returns an ack byte or read data to the TX FIFO.
module uart_cmd_bridge #(
    parameter int unsigned DataBytes   = 4,
    parameter int unsigned TimeoutBits = 24
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [TimeoutBits-1:0] c_timeout_cyc,
    input  logic                   i_rx_empty,
    output logic                   o_rx_read,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_tx_full,
    output logic                   o_tx_write,
    output logic [7:0]             o_tx_wdata,
    output logic                   o_bus_req,
    output logic                   o_bus_we,
    output logic [7:0]             o_bus_addr,
    output logic [8*DataBytes-1:0] o_bus_wdata,
    input  logic                   i_bus_ack,
    input  logic [8*DataBytes-1:0] i_bus_rdata,
    output logic                   o_busy,
    output logic [7:0]             o_err_cnt
);

    localparam int unsigned W = 8 * DataBytes;
    localparam logic [1:0] LastByte = 2'(DataBytes - 1);
    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] AckByte  = 8'h4B;

    typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

    state_e                 state_q;
    logic [1:0]             cnt_q;
    logic [TimeoutBits-1:0] tmo_q;
    logic [W-1:0]           resp_q;
    logic [W-1:0]           wdata_next;
    logic                   rx_pop;
    logic                   tmo_fire;
    logic                   err_event;

    // Handshakes, response byte select, and error/timeout qualifiers
    always_comb begin
        rx_pop     = !i_rst && !i_rx_empty && (state_q inside {StIdle, StAddr, StData});
        o_rx_read  = rx_pop;
        o_tx_write = !i_rst && (state_q == StResp) && !i_tx_full;
        o_tx_wdata = o_bus_we ? AckByte : 8'(resp_q >> {cnt_q, 3'b000});
        o_busy     = (state_q != StIdle);
        // New byte enters at the MSB end so the first byte lands in [7:0]
        wdata_next = (o_bus_wdata >> 8) | (W'(i_rx_data) << (W - 8));
        // Fires when the counter would hit zero with no byte arriving
        tmo_fire   = (state_q inside {StAddr, StData}) && i_rx_empty &&
                     (c_timeout_cyc != '0) && (tmo_q <= TimeoutBits'(1));
        err_event  = tmo_fire ||
                     (rx_pop && (state_q == StIdle) &&
                      (i_rx_data != CmdWrite) && (i_rx_data != CmdRead));
    end

    // Packet FSM with registered bus outputs, counters and error count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tmo_q       <= '0;
            resp_q      <= '0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_err_cnt   <= '0;
        end else begin
            if (err_event && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (rx_pop && (i_rx_data == CmdWrite)) begin
                        o_bus_we <= 1'b1;
                        tmo_q    <= c_timeout_cyc;
                        state_q  <= StAddr;
                    end else if (rx_pop && (i_rx_data == CmdRead)) begin
                        o_bus_we <= 1'b0;
                        tmo_q    <= c_timeout_cyc;
                        state_q  <= StAddr;
                    end
                end
                StAddr: begin
                    if (rx_pop) begin
                        o_bus_addr <= i_rx_data;
                        tmo_q      <= c_timeout_cyc;
                        cnt_q      <= '0;
                        if (o_bus_we) begin
                            state_q <= StData;
                        end else begin
                            o_bus_req <= 1'b1;
                            state_q   <= StBus;
                        end
                    end else if (tmo_fire) begin
                        state_q <= StIdle;
                    end else if (tmo_q != '0) begin
                        tmo_q <= tmo_q - TimeoutBits'(1);
                    end
                end
                StData: begin
                    if (rx_pop) begin
                        o_bus_wdata <= wdata_next;
                        tmo_q       <= c_timeout_cyc;
                        if (cnt_q == LastByte) begin
                            o_bus_req <= 1'b1;
                            state_q   <= StBus;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end else if (tmo_fire) begin
                        state_q <= StIdle;
                    end else if (tmo_q != '0) begin
                        tmo_q <= tmo_q - TimeoutBits'(1);
                    end
                end
                StBus: begin
                    if (o_bus_req && i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        resp_q    <= i_bus_rdata;
                        cnt_q     <= '0;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (!i_tx_full) begin
                        if (o_bus_we || (cnt_q == LastByte)) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: RX FIFO model, bus responder,
// and TX/bus scoreboards fed from a vector table plus corner-case sequences.
module tb_uart_cmd_bridge;

    localparam int unsigned DataBytes   = 4;
    localparam int unsigned TimeoutBits = 24;

    logic                   i_clk = 1'b0;
    logic                   i_rst = 1'b1;
    logic [TimeoutBits-1:0] c_timeout_cyc = '0;
    logic                   i_rx_empty = 1'b1;
    logic                   o_rx_read;
    logic [7:0]             i_rx_data = 8'h00;
    logic                   i_tx_full = 1'b0;
    logic                   o_tx_write;
    logic [7:0]             o_tx_wdata;
    logic                   o_bus_req;
    logic                   o_bus_we;
    logic [7:0]             o_bus_addr;
    logic [31:0]            o_bus_wdata;
    logic                   i_bus_ack = 1'b0;
    logic [31:0]            i_bus_rdata = '0;
    logic                   o_busy;
    logic [7:0]             o_err_cnt;

    uart_cmd_bridge #(.DataBytes(DataBytes), .TimeoutBits(TimeoutBits)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .c_timeout_cyc(c_timeout_cyc),
        .i_rx_empty   (i_rx_empty),
        .o_rx_read    (o_rx_read),
        .i_rx_data    (i_rx_data),
        .i_tx_full    (i_tx_full),
        .o_tx_write   (o_tx_write),
        .o_tx_wdata   (o_tx_wdata),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ack    (i_bus_ack),
        .i_bus_rdata  (i_bus_rdata),
        .o_busy       (o_busy),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;     // write data sent, or read data returned by the bus
        int          delay;    // cycles from req rise to ack
        logic [31:0] exp_tx;   // expected TX bytes, LSB first
        int          exp_n;
        int          exp_lat;  // cycles from first byte available to req
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          tx_seen = 0;
    int          ack_delay = 0;
    logic [31:0] ack_rdata = '0;
    bit          in_txn = 1'b0;
    int          dcnt = 0;
    int          req_cyc = 0;
    logic        rx_popped;
    bus_t        rsp_exp;
    logic [7:0]  mon_exp;

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rx_refresh();
        i_rx_empty = (rx_q.size() == 0);
        i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_q.push_back(b);
        rx_refresh();
    endtask

    // Test stimulus is applied 2 time units after the edge, after the models
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    always @(posedge i_clk) cyc++;

    // First-word-fall-through RX FIFO model
    always @(posedge i_clk) begin
        rx_popped = o_rx_read;
        #1;
        if (rx_popped && rx_q.size() != 0) void'(rx_q.pop_front());
        rx_refresh();
    end

    // Bus responder: checks each new request against the expected queue
    always @(posedge i_clk) begin
        #1;
        i_bus_ack = 1'b0;
        if (!o_bus_req) begin
            in_txn = 1'b0;
        end else begin
            if (!in_txn) begin
                in_txn  = 1'b1;
                dcnt    = 0;
                req_cyc = cyc;
                if (exp_bus.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL bus_unexpected: got req addr 0x%0h, expected no request",
                             o_bus_addr);
                end else begin
                    rsp_exp = exp_bus.pop_front();
                    check("bus_we", 32'(o_bus_we), 32'(rsp_exp.we));
                    check("bus_addr", 32'(o_bus_addr), 32'(rsp_exp.addr));
                    if (rsp_exp.we) check("bus_wdata", o_bus_wdata, rsp_exp.wdata);
                end
            end
            if (dcnt == ack_delay) begin
                i_bus_ack   = 1'b1;
                i_bus_rdata = ack_rdata;
            end
            dcnt++;
        end
    end

    // TX scoreboard, sampled mid-cycle
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_tx_write && i_tx_full) begin
                n_checks++;
                n_errors++;
                $display("FAIL tx_push_while_full: got write=1, expected 0");
            end
            if (o_tx_write) begin
                tx_seen++;
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no byte", o_tx_wdata);
                end else begin
                    mon_exp = exp_tx.pop_front();
                    check("tx_byte", 32'(o_tx_wdata), 32'(mon_exp));
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((o_busy || rx_q.size() != 0 || exp_tx.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("done_in_budget", 32'(n < budget), 32'd1);
        check("bus_all_seen", 32'(exp_bus.size()), 32'd0);
        check("busy_after", 32'(o_busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        bus_t b;
        int   start;
        ack_delay = v.delay;
        ack_rdata = v.we ? 32'h0 : v.data;
        b.we      = v.we;
        b.addr    = v.addr;
        b.wdata   = v.we ? v.data : 32'h0;
        exp_bus.push_back(b);
        for (int i = 0; i < v.exp_n; i++) exp_tx.push_back(v.exp_tx[8*i +: 8]);
        start = cyc;
        rx_push(v.we ? 8'h57 : 8'h52);
        rx_push(v.addr);
        if (v.we) for (int i = 0; i < DataBytes; i++) rx_push(v.data[8*i +: 8]);
        wait_done(200);
        check("req_latency", 32'(req_cyc - start), 32'(v.exp_lat));
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int seen;
        vecs[0] = '{we: 1'b1, addr: 8'h10, data: 32'hDEADBEEF, delay: 3,
                    exp_tx: 32'h4B, exp_n: 1, exp_lat: 6};
        vecs[1] = '{we: 1'b0, addr: 8'h20, data: 32'h12345678, delay: 0,
                    exp_tx: 32'h12345678, exp_n: 4, exp_lat: 2};
        vecs[2] = '{we: 1'b1, addr: 8'hFF, data: 32'h00000001, delay: 0,
                    exp_tx: 32'h4B, exp_n: 1, exp_lat: 6};
        vecs[3] = '{we: 1'b0, addr: 8'h00, data: 32'hA5C30F80, delay: 7,
                    exp_tx: 32'hA5C30F80, exp_n: 4, exp_lat: 2};
        vecs[4] = '{we: 1'b1, addr: 8'h7E, data: 32'hFFFFFFFF, delay: 1,
                    exp_tx: 32'h4B, exp_n: 1, exp_lat: 6};

        // Reset state, including no pop while reset is held
        i_rst = 1'b1;
        repeat (3) tick();
        check("rst_bus_req", 32'(o_bus_req), 32'd0);
        check("rst_err_cnt", 32'(o_err_cnt), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_tx_write", 32'(o_tx_write), 32'd0);
        rx_push(8'h57);
        #1;
        check("rst_rx_read", 32'(o_rx_read), 32'd0);
        rx_q.delete();
        rx_refresh();
        i_rst = 1'b0;
        tick();

        // Table-driven packets
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            check("err_cnt_clean", 32'(o_err_cnt), 32'd0);
        end

        // Backpressure mid-response
        ack_delay = 2;
        ack_rdata = 32'hCAFEF00D;
        exp_bus.push_back('{we: 1'b0, addr: 8'h44, wdata: 32'h0});
        for (int i = 0; i < 4; i++) exp_tx.push_back(ack_rdata[8*i +: 8]);
        seen = tx_seen;
        rx_push(8'h52);
        rx_push(8'h44);
        n = 0;
        while (tx_seen == seen && n < 100) begin
            tick();
            n++;
        end
        check("bp_first_byte", 32'(tx_seen - seen), 32'd1);
        i_tx_full = 1'b1;
        repeat (5) tick();
        check("bp_no_push", 32'(tx_seen - seen), 32'd1);
        check("bp_hold_byte", 32'(o_tx_wdata), 32'hF0);
        i_tx_full = 1'b0;
        wait_done(100);
        check("bp_total", 32'(tx_seen - seen), 32'd4);

        // Garbage byte, then a truncated write that times out
        c_timeout_cyc = 24'd100;
        rx_push(8'h41);
        rx_push(8'h57);
        rx_push(8'h10);
        rx_push(8'hAB);
        n = 0;
        while (rx_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("tmo_busy_start", 32'(o_busy), 32'd1);
        n = 0;
        while (o_busy && n < 200) begin
            tick();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd100);
        check("tmo_err_cnt", 32'(o_err_cnt), 32'd2);
        check("tmo_no_req", 32'(o_bus_req), 32'd0);
        run_vec('{we: 1'b0, addr: 8'h21, data: 32'h0BADF00D, delay: 1,
                  exp_tx: 32'h0BADF00D, exp_n: 4, exp_lat: 2});

        // Error counter saturation
        for (int i = 0; i < 300; i++) rx_push(8'h00);
        n = 0;
        while (rx_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        tick();
        check("sat_err_cnt", 32'(o_err_cnt), 32'd255);
        check("sat_busy", 32'(o_busy), 32'd0);

        // Reset while the bus request is outstanding
        ack_delay = 100000;
        exp_bus.push_back('{we: 1'b0, addr: 8'h30, wdata: 32'h0});
        rx_push(8'h52);
        rx_push(8'h30);
        n = 0;
        while (!o_bus_req && n < 50) begin
            tick();
            n++;
        end
        check("rstbus_req_seen", 32'(o_bus_req), 32'd1);
        seen = tx_seen;
        i_rst = 1'b1;
        #1;
        check("rstbus_req_drop", 32'(o_bus_req), 32'd0);
        check("rstbus_tx_write", 32'(o_tx_write), 32'd0);
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
        check("rstbus_busy", 32'(o_busy), 32'd0);
        check("rstbus_err_cnt", 32'(o_err_cnt), 32'd0);
        repeat (20) tick();
        check("rstbus_no_tx", 32'(tx_seen - seen), 32'd0);
        check("rstbus_bus_seen", 32'(exp_bus.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
Byte-stream command decoder sitting directly downstream of the UART receiver's FIFO and upstream of the UART transmitter's FIFO. It pops received bytes, assembles read/write command packets, and issues one register-bus transaction per packet. It returns an acknowledge byte (write) or the read data bytes (read) to the TX FIFO. Together with the UART this forms the chip's debug/configuration register port.

Parameters:
DataBytes, 4, register data width in bytes (1..4); bus data width = 8*DataBytes
TimeoutBits, 24, width of the inter-byte timeout configuration

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-high
c_timeout_cyc  in  TimeoutBits  max idle cycles between bytes of one packet; 0 = timeout disabled
i_rx_empty  in  1  RX FIFO empty
o_rx_read  out  1  pop RX FIFO this cycle
i_rx_data  in  8  RX FIFO head byte; valid whenever i_rx_empty=0 (first-word-fall-through)
i_tx_full  in  1  TX FIFO full
o_tx_write  out  1  push o_tx_wdata into TX FIFO this cycle
o_tx_wdata  out  8  byte to transmit
o_bus_req  out  1  register bus request
o_bus_we  out  1  1=write, 0=read; stable while o_bus_req=1
o_bus_addr  out  8  register address; stable while o_bus_req=1
o_bus_wdata  out  8*DataBytes  write data; stable while o_bus_req=1
i_bus_ack  in  1  single-cycle transaction completion
i_bus_rdata  in  8*DataBytes  read data; valid in the i_bus_ack cycle
o_busy  out  1  state != IDLE
o_err_cnt  out  8  saturating count of protocol errors

Behaviour:
- Packet format: write = 0x57 ('W'), addr, DataBytes data bytes LSB first. Read = 0x52 ('R'), addr.
- States: IDLE, ADDR, DATA, BUS, RESP. All registers asynchronously reset on i_rst: state=IDLE, counters=0, o_bus_req=0, o_err_cnt=0. During reset o_rx_read=0 and o_tx_write=0.
- o_rx_read = !i_rx_empty && state in {IDLE, ADDR, DATA}. This is combinational; the byte is consumed in the same cycle.
- IDLE: on a popped byte, 0x57 -> ADDR (we=1); 0x52 -> ADDR (we=0). Any other value is dropped, o_err_cnt+1, and the state stays IDLE.
- ADDR: popped byte -> o_bus_addr. Next state is DATA if we, else BUS.
- DATA: each popped byte is shifted into o_bus_wdata from the MSB side, so the first byte ends up in bits [7:0]. Byte counter 0..DataBytes-1. After the last byte -> BUS.
- Timeout counter:
  - Loaded with c_timeout_cyc on entry to ADDR and on every byte popped in ADDR/DATA.
  - Decrements each cycle in ADDR/DATA while i_rx_empty=1.
  - When it reaches 0 (and c_timeout_cyc != 0): -> IDLE, o_err_cnt+1, partial packet discarded.
  - Not active in IDLE, BUS or RESP.
- BUS:
  - o_bus_req is registered: it rises on the first BUS cycle and stays high until i_bus_ack is sampled high.
  - It falls the cycle after ack; the state moves to RESP in the same cycle.
  - i_bus_rdata is captured into a response register on ack.
  - i_bus_ack while o_bus_req=0 is ignored.
  - No timeout: a hung bus holds BUS until reset.
- RESP:
  - o_tx_write = !i_tx_full.
  - Write response: single byte 0x4B ('K').
  - Read response: DataBytes bytes, LSB first, from the captured data.
  - Byte counter advances only on push. After the last push -> IDLE.
  - While i_tx_full=1, o_tx_wdata is held and no push occurs.
- o_err_cnt saturates at 255 (no wrap).
- Latency: with bytes available back-to-back, a write packet pops in cycles 0..5 (DataBytes=4) and o_bus_req is high from cycle 6. A read pops in cycles 0..1 with req high from cycle 2. Ack at cycle N gives the first o_tx_write at cycle N+1.
- Reset mid-transaction drops o_bus_req immediately and abandons any partial response.

Test Plan:
- Write: RX 57 10 EF BE AD DE, ack 3 cycles after req -> one req with we=1, addr=0x10, wdata=0xDEADBEEF; TX receives exactly 0x4B; o_busy low afterwards.
- Read: RX 52 20, ack with rdata=0x12345678 -> req with we=0, addr=0x20; TX receives 78 56 34 12 in order.
- Backpressure: read response with i_tx_full high for 5 cycles mid-response -> no pushes while full, byte order intact, no duplicated byte.
- Garbage and timeout: RX 0x41 then 57 10 AB followed by silence with c_timeout_cyc=100 -> o_err_cnt=2, return to IDLE 100 cycles after the last byte, no bus req. A following valid read packet completes normally.
- Saturation: 300 invalid bytes -> o_err_cnt=255.
- Reset in BUS: assert i_rst while o_bus_req=1 -> o_bus_req=0 asynchronously; after release o_busy=0, o_err_cnt=0, and no TX bytes are produced.
